// File: rtl/data_mem_resp_pkg.sv
// Shared constants for the data-side memory responder: MMIO register offsets,
// CTRL bit positions and the timer compare reset value.
package data_mem_resp_pkg;

  localparam logic [3:0] OFF_GPIO  = 4'h0;
  localparam logic [3:0] OFF_TIMER = 4'h4;
  localparam logic [3:0] OFF_CMP   = 4'h8;
  localparam logic [3:0] OFF_CTRL  = 4'hC;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_MATCH  = 1;
  localparam int CTRL_ERR    = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_mem_resp_mmio_timer.sv
// Free-running timer with compare, sticky MATCH/ERR flags and the timer
// interrupt; register writes arrive already decoded by the top.
module mmio_timer
  import data_mem_resp_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_timer,
  input  logic        i_wr_cmp,
  input  logic        i_wr_ctrl,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wdata,
  input  logic        i_err_evt,
  output logic [31:0] o_timer,
  output logic [31:0] o_cmp,
  output logic [31:0] o_ctrl,
  output logic        o_irq
);

  logic [31:0] r_timer;
  logic [31:0] r_cmp;
  logic        r_en;
  logic        r_match;
  logic        r_err;
  logic        r_irq_en;

  logic w_ctrl_wr;
  logic w_hit;

  assign w_ctrl_wr = i_wr_ctrl & i_be[0];
  // Compare uses the value held before this edge's increment or write.
  assign w_hit     = r_en & (r_timer == r_cmp);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_timer  <= '0;
      r_cmp    <= TIMER_CMP_RST;
      r_en     <= 1'b0;
      r_match  <= 1'b0;
      r_err    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      if (i_wr_timer) begin
        r_timer <= be_merge(r_timer, i_wdata, i_be);
      end else if (r_en) begin
        r_timer <= r_timer + 32'd1;
      end

      if (i_wr_cmp) r_cmp <= be_merge(r_cmp, i_wdata, i_be);

      if (w_ctrl_wr) begin
        r_en     <= i_wdata[CTRL_EN];
        r_irq_en <= i_wdata[CTRL_IRQ_EN];
      end

      // Sticky flags: a new event wins over a same-cycle write-one-to-clear.
      r_match <= w_hit | (r_match & ~(w_ctrl_wr & i_wdata[CTRL_MATCH]));
      r_err   <= i_err_evt | (r_err & ~(w_ctrl_wr & i_wdata[CTRL_ERR]));
    end
  end

  always_comb begin
    o_ctrl              = '0;
    o_ctrl[CTRL_EN]     = r_en;
    o_ctrl[CTRL_MATCH]  = r_match;
    o_ctrl[CTRL_ERR]    = r_err;
    o_ctrl[CTRL_IRQ_EN] = r_irq_en;
  end

  assign o_timer = r_timer;
  assign o_cmp   = r_cmp;
  assign o_irq   = r_match & r_irq_en;

endmodule

// File: rtl/data_mem_resp.sv
// Core data-port responder: word RAM with byte-lane writes, a 16-byte MMIO
// window (GPIO + timer block) and combinational zero-latency reads.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000
)(
  input  logic        Clk_Core,
  input  logic        Rst_Core_N,
  input  logic [31:0] Mem_Data_Addr,
  input  logic [31:0] Mem_Data_Write,
  input  logic        Mem_Read_Ctrl,
  input  logic [3:0]  Mem_Write_Ctrl,
  output logic [31:0] Mem_Data_Read,
  output logic [31:0] Gpio_Out,
  output logic        Timer_Irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_gpio;

  logic [29:0]   w_word;
  logic [AW-1:0] w_ram_idx;
  logic [3:0]    w_off;
  logic          w_is_ram;
  logic          w_is_mmio;
  logic          w_we;
  logic          w_access;
  logic          w_err_evt;
  logic          w_mmio_wr;
  logic          w_addr_unused;
  logic [31:0]   w_timer;
  logic [31:0]   w_cmp;
  logic [31:0]   w_ctrl;
  logic [31:0]   w_rdata;

  // Byte offset within a word carries no meaning for decode or lane select.
  assign w_addr_unused = ^Mem_Data_Addr[1:0];

  assign w_word    = Mem_Data_Addr[31:2];
  assign w_ram_idx = Mem_Data_Addr[AW+1:2];
  assign w_off     = {Mem_Data_Addr[3:2], 2'b00};
  assign w_is_ram  = (w_word < 30'(RAM_WORDS));
  assign w_is_mmio = ~w_is_ram & (Mem_Data_Addr[31:4] == MMIO_BASE[31:4]);

  assign w_we      = (Mem_Write_Ctrl != 4'h0);
  assign w_access  = Mem_Read_Ctrl | w_we;
  assign w_err_evt = (w_access & ~w_is_ram & ~w_is_mmio) | (Mem_Read_Ctrl & w_we);
  assign w_mmio_wr = w_is_mmio & w_we;

  // No reset on the array; writes are simply blocked while reset is held.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core_N && w_is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (Mem_Write_Ctrl[i]) r_ram[w_ram_idx][8*i +: 8] <= Mem_Data_Write[8*i +: 8];
      end
    end
  end

  always_ff @(posedge Clk_Core) begin
    if (!Rst_Core_N) begin
      r_gpio <= '0;
    end else if (w_mmio_wr && (w_off == OFF_GPIO)) begin
      r_gpio <= be_merge(r_gpio, Mem_Data_Write, Mem_Write_Ctrl);
    end
  end

  mmio_timer u_timer (
    .i_clk      (Clk_Core),
    .i_rst_n    (Rst_Core_N),
    .i_wr_timer (w_mmio_wr && (w_off == OFF_TIMER)),
    .i_wr_cmp   (w_mmio_wr && (w_off == OFF_CMP)),
    .i_wr_ctrl  (w_mmio_wr && (w_off == OFF_CTRL)),
    .i_be       (Mem_Write_Ctrl),
    .i_wdata    (Mem_Data_Write),
    .i_err_evt  (w_err_evt),
    .o_timer    (w_timer),
    .o_cmp      (w_cmp),
    .o_ctrl     (w_ctrl),
    .o_irq      (Timer_Irq)
  );

  always_comb begin
    w_rdata = '0;
    if (Mem_Read_Ctrl) begin
      if (w_is_ram) begin
        w_rdata = r_ram[w_ram_idx];
      end else if (w_is_mmio) begin
        case (w_off)
          OFF_GPIO:  w_rdata = r_gpio;
          OFF_TIMER: w_rdata = w_timer;
          OFF_CMP:   w_rdata = w_cmp;
          OFF_CTRL:  w_rdata = w_ctrl;
          default:   w_rdata = '0;
        endcase
      end
    end
  end

  assign Mem_Data_Read = w_rdata;
  assign Gpio_Out      = r_gpio;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed plus random stimulus against an address-map level reference model.
module tb_data_mem_resp;

  localparam logic [31:0] MB        = 32'h0001_0000;
  localparam logic [31:0] RAM_BYTES = 32'h0000_1000;

  logic        Clk_Core;
  logic        Rst_Core_N;
  logic [31:0] Mem_Data_Addr;
  logic [31:0] Mem_Data_Write;
  logic        Mem_Read_Ctrl;
  logic [3:0]  Mem_Write_Ctrl;
  logic [31:0] Mem_Data_Read;
  logic [31:0] Gpio_Out;
  logic        Timer_Irq;

  data_mem_resp #(.RAM_WORDS(1024), .MMIO_BASE(MB)) dut (
    .Clk_Core       (Clk_Core),
    .Rst_Core_N     (Rst_Core_N),
    .Mem_Data_Addr  (Mem_Data_Addr),
    .Mem_Data_Write (Mem_Data_Write),
    .Mem_Read_Ctrl  (Mem_Read_Ctrl),
    .Mem_Write_Ctrl (Mem_Write_Ctrl),
    .Mem_Data_Read  (Mem_Data_Read),
    .Gpio_Out       (Gpio_Out),
    .Timer_Irq      (Timer_Irq)
  );

  initial Clk_Core = 1'b0;
  always #5 Clk_Core = ~Clk_Core;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_ram [0:1023];
  logic [31:0] m_gpio, m_timer, m_cmp;
  logic        m_en, m_match, m_err, m_irqen;

  logic [31:0] obs_rd, obs_gpio;
  logic        obs_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r = r + (((n >> (8*i)) & 32'hFF) << (8*i));
      else       r = r + (((o >> (8*i)) & 32'hFF) << (8*i));
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
    if (!rd) return 0;
    if (a < RAM_BYTES) return m_ram[a / 4];
    if ((a - (a % 16)) == MB) begin
      case ((a % 16) / 4)
        0: return m_gpio;
        1: return m_timer;
        2: return m_cmp;
        default: return 32'(m_en) + 32'(m_match) * 2 + 32'(m_err) * 4 + 32'(m_irqen) * 8;
      endcase
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_gpio = 0; m_timer = 0; m_cmp = 32'hFFFF_FFFF;
    m_en = 0; m_match = 0; m_err = 0; m_irqen = 0;
  endtask

  task automatic model_edge(input logic rst_n, input logic [31:0] a, input logic [31:0] wd,
                            input logic rd, input logic [3:0] be);
    logic wr, ram, mm, err_evt, hit;
    logic [31:0] t_next;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wr      = (be != 0);
    ram     = (a < RAM_BYTES);
    mm      = !ram && ((a - (a % 16)) == MB);
    err_evt = ((rd || wr) && !ram && !mm) || (rd && wr);
    hit     = m_en && (m_timer == m_cmp);
    t_next  = m_en ? m_timer + 1 : m_timer;
    if (wr && ram) m_ram[a / 4] = merge(m_ram[a / 4], wd, be);
    if (wr && mm) begin
      case ((a % 16) / 4)
        0: m_gpio = merge(m_gpio, wd, be);
        1: t_next = merge(m_timer, wd, be);
        2: m_cmp  = merge(m_cmp, wd, be);
        default: if (be[0]) begin
          m_en    = wd[0];
          m_irqen = wd[3];
          if (wd[1]) m_match = 0;
          if (wd[2]) m_err   = 0;
        end
      endcase
    end
    m_timer = t_next;
    if (hit)     m_match = 1;
    if (err_evt) m_err   = 1;
  endtask

  // One clock: drive, sample mid-cycle against the model, advance the model.
  task automatic cycle(input logic rst_n, input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic [3:0] be);
    Rst_Core_N = rst_n; Mem_Data_Addr = a; Mem_Data_Write = wd;
    Mem_Read_Ctrl = rd; Mem_Write_Ctrl = be;
    @(negedge Clk_Core);
    obs_rd = Mem_Data_Read; obs_gpio = Gpio_Out; obs_irq = Timer_Irq;
    chk("rdata", obs_rd, model_read(a, rd));
    chk("gpio", obs_gpio, m_gpio);
    chk("irq", {31'b0, obs_irq}, {31'b0, m_match & m_irqen});
    model_edge(rst_n, a, wd, rd, be);
    @(posedge Clk_Core); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, a, d, 1'b0, 4'hF);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(1'b1, a, 32'h0, 1'b1, 4'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic        r;
    logic [3:0]  be;
    int          kind;

    Rst_Core_N = 0; Mem_Data_Addr = 0; Mem_Data_Write = 0;
    Mem_Read_Ctrl = 0; Mem_Write_Ctrl = 0;
    repeat (2) @(posedge Clk_Core);
    #1;
    model_reset();

    // Writes while reset is held are discarded
    cycle(1'b0, MB, 32'hFFFF_FFFF, 1'b0, 4'hF);
    rd(MB + 8);
    chk("rst_cmp", obs_rd, 32'hFFFF_FFFF);
    chk("rst_gpio", obs_gpio, 32'h0);
    chk("rst_irq", {31'b0, obs_irq}, 32'h0);
    rd(MB + 12);
    chk("rst_ctrl", obs_rd, 32'h0);

    for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom);

    // Byte-lane write merge
    wr(32'h10, 32'h1122_3344);
    cycle(1'b1, 32'h10, 32'h00A5_0000, 1'b0, 4'b0100);
    rd(32'h10);
    chk("lane2", obs_rd, 32'h11A5_3344);

    // Read of a word being written returns the old value
    cycle(1'b1, 32'h10, 32'hFFFF_FFFF, 1'b1, 4'hF);
    chk("rd_pre_wr", obs_rd, 32'h11A5_3344);
    wr(MB + 12, 32'h4);
    rd(32'h10);
    chk("wr_done", obs_rd, 32'hFFFF_FFFF);

    // Compare match and interrupt
    wr(MB + 8, 32'd5);
    wr(MB + 4, 32'd0);
    wr(MB + 12, 32'h9);
    for (int k = 0; k < 6; k++) begin
      rd(32'h0);
      chk("irq_pre", {31'b0, obs_irq}, 32'h0);
    end
    wr(MB + 12, 32'h2);
    chk("irq_set", {31'b0, obs_irq}, 32'h1);
    rd(MB + 12);
    chk("irq_clr", {31'b0, obs_irq}, 32'h0);
    chk("ctrl_clr", obs_rd, 32'h0);

    // Timer wrap
    wr(MB + 4, 32'hFFFF_FFFE);
    wr(MB + 12, 32'h1);
    rd(MB + 4);
    chk("wrap0", obs_rd, 32'hFFFF_FFFE);
    rd(MB + 4);
    chk("wrap1", obs_rd, 32'hFFFF_FFFF);
    rd(MB + 4);
    chk("wrap2", obs_rd, 32'h0);

    // Software write beats increment
    wr(MB + 4, 32'h100);
    rd(MB + 4);
    chk("tw0", obs_rd, 32'h100);
    rd(MB + 4);
    chk("tw1", obs_rd, 32'h101);

    // ERR: unmapped, W1C, set-beats-clear, conflict
    rd(32'h0002_0000);
    chk("unmap_rd", obs_rd, 32'h0);
    rd(MB + 12);
    chk("err_set", obs_rd & 32'h4, 32'h4);
    wr(MB + 12, 32'h4);
    rd(MB + 12);
    chk("err_w1c", obs_rd, 32'h0);
    cycle(1'b1, MB + 12, 32'h4, 1'b1, 4'h1);
    rd(MB + 12);
    chk("err_sticky", obs_rd, 32'h4);
    wr(32'h0002_0000, 32'hDEAD_BEEF);
    wr(MB + 20, 32'hDEAD_BEEF);

    // RAM boundary
    wr(32'hFFC, 32'h5A5A_1234);
    rd(32'hFFE);
    chk("ram_last", obs_rd, 32'h5A5A_1234);
    rd(RAM_BYTES);
    chk("ram_past", obs_rd, 32'h0);
    wr(MB + 12, 32'h4);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: a = 32'($urandom_range(0, 15)) * 4;
        4, 5, 6:    a = MB + 32'($urandom_range(0, 3)) * 4;
        7:          a = 32'hFFC;
        8: begin
          case ($urandom_range(0, 2))
            0: a = RAM_BYTES;
            1: a = 32'h0002_0000;
            default: a = MB + 16;
          endcase
        end
        default: a = 32'h0;
      endcase
      a  = a + 32'($urandom_range(0, 3));
      r  = ($urandom_range(0, 1) == 1);
      be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      d  = $urandom;
      if ((a >= MB) && (a < MB + 16) && ($urandom_range(0, 1) == 1)) d = 32'($urandom_range(0, 40)) | 32'h8;
      cycle(($urandom_range(0, 49) != 0), a, d, r, be);
    end

    // Reset mid-count keeps RAM
    wr(MB + 12, 32'h1);
    wr(MB + 4, 32'h50);
    wr(MB, 32'hFF);
    wr(32'h20, 32'hCAFE_F00D);
    cycle(1'b0, 32'h20, 32'h1234_5678, 1'b0, 4'hF);
    rd(MB + 4);
    chk("rst_timer", obs_rd, 32'h0);
    chk("rst_gpio2", obs_gpio, 32'h0);
    rd(MB);
    chk("rst_gpio_rd", obs_rd, 32'h0);
    rd(32'h20);
    chk("ram_kept", obs_rd, 32'hCAFE_F00D);
    rd(MB + 4);
    chk("timer_stop", obs_rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter RAM_WORDS, 1024, number of 32-bit RAM words (power of two).
REQ-002 Parameter MMIO_BASE, 32'h0001_0000, base address of the 16-byte register window.
REQ-003 Clk_Core  input  1  single clock; all state updates on rising edge.
REQ-004 Rst_Core_N  input  1  reset, synchronous and active-low.
REQ-005 Mem_Data_Addr  input  32  byte address from core.
REQ-006 Mem_Data_Write  input  32  write data, already lane-aligned by core.
REQ-007 Mem_Read_Ctrl  input  1  read request.
REQ-008 Mem_Write_Ctrl  input  4  byte write enables; bit n enables byte lane n.
REQ-009 Mem_Data_Read  output  32  read data to core.
REQ-010 Gpio_Out  output  32  GPIO output register.
REQ-011 Timer_Irq  output  1  timer interrupt request.

Function
REQ-012 Decode on Mem_Data_Addr[31:2]: RAM if address < RAM_WORDS*4; MMIO if address in MMIO_BASE..MMIO_BASE+0xF; otherwise unmapped.
REQ-013 Read path SHALL be combinational, zero latency: Mem_Data_Read valid same cycle as address with Mem_Read_Ctrl=1; Mem_Data_Read = 0 when Mem_Read_Ctrl=0 or unmapped.
REQ-014 Writes SHALL commit at the rising edge for each lane with Mem_Write_Ctrl bit set; unset lanes unchanged.
REQ-015 Read and write to same location in one cycle: read returns pre-write value.
REQ-016 MMIO +0x0 GPIO_OUT: RW, drives Gpio_Out; byte enables honored.
REQ-017 MMIO +0x4 TIMER: RW 32-bit counter; increments by 1 each cycle while CTRL.EN=1; wraps 0xFFFF_FFFF -> 0.
REQ-018 Software write to TIMER SHALL take priority over increment in same cycle.
REQ-019 MMIO +0x8 TIMER_CMP: RW compare value, byte enables honored.
REQ-020 MMIO +0xC CTRL: bit0 EN (RW), bit1 MATCH (sticky, W1C), bit2 ERR (sticky, W1C), bit3 IRQ_EN (RW); bits 31:4 read 0, writes ignored.
REQ-021 MATCH SHALL set on the edge where EN=1 and TIMER == TIMER_CMP (pre-increment value); set beats W1C in same cycle.
REQ-022 ERR SHALL set on any unmapped access (read or write), or when Mem_Read_Ctrl=1 and Mem_Write_Ctrl != 0 simultaneously; set beats W1C; the write still commits if mapped.
REQ-023 Timer_Irq = MATCH & IRQ_EN, registered-state only, no combinational input path.
REQ-024 Unmapped writes SHALL modify no state other than ERR.
REQ-025 Only Mem_Data_Addr[1:0]=0 is meaningful; bits [1:0] ignored for decode.

Reset
REQ-026 On Rst_Core_N=0 at an edge: GPIO_OUT=0, TIMER=0, TIMER_CMP=32'hFFFF_FFFF, CTRL=0; Timer_Irq=0 next cycle.
REQ-027 RAM contents SHALL NOT be reset; writes during reset are discarded (RAM and MMIO).
REQ-028 Reset asserted mid-count SHALL stop and clear TIMER the same edge.

Structure
REQ-029 Shared package holds MMIO offsets (0x0/0x4/0x8/0xC), CTRL bit indices, TIMER_CMP reset value.
REQ-030 One sub-module, mmio_timer (TIMER, TIMER_CMP, CTRL, Timer_Irq); RAM array and decode in top.

Verification
REQ-031 Write 0xA5 lane 2 (Write_Ctrl=4'b0100) to 0x10 over 0x1122_3344 -> read 0x10 returns 0x11A5_3344.
REQ-032 CMP=5, EN=1, IRQ_EN=1 from TIMER=0 -> MATCH set on 6th edge, Timer_Irq=1 thereafter; write CTRL=0x2 -> Timer_Irq=0 next cycle.
REQ-033 TIMER=0xFFFF_FFFE, EN=1 -> reads 0xFFFF_FFFF then 0x0000_0000.
REQ-034 Read 0x0002_0000 -> Mem_Data_Read=0, ERR=1; write CTRL=0x4 -> ERR=0; simultaneous set and clear -> ERR stays 1.
REQ-035 Software write TIMER=0x100 while EN=1 -> next read 0x100, following cycle 0x101.
REQ-036 Assert reset with TIMER=0x50, GPIO_OUT=0xFF -> both read 0; previously written RAM word unchanged.
